// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking-network output layer.
// FSM encoding, datapath widths and the per-beat weighted-sum helper.
package snn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_COMPUTE,
        ST_FIRE,
        ST_DONE
    } state_t;

    localparam int BEATS  = 144;
    localparam int LANES  = 4;
    localparam int W_W    = 8;
    localparam int MEM_W  = 16;
    localparam int ACC_W  = 18;
    localparam int ADDR_W = 11;
    localparam int WORD_W = LANES * W_W;

    // Sum of the signed weights whose lane spiked in this beat.
    function automatic logic signed [ACC_W-1:0] beat_sum(
        input logic [WORD_W-1:0] w,
        input logic [LANES-1:0]  spk
    );
        logic signed [ACC_W-1:0] s;
        s = '0;
        for (int k = 0; k < LANES; k++) begin
            if (spk[k]) begin
                s = s + {{(ACC_W-W_W){w[W_W*k+W_W-1]}}, w[W_W*k +: W_W]};
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/lif_update.sv
// Leaky integrate-and-fire step: V - (V >>> LEAK_SHIFT) + acc, saturated.
// Ports: v/acc in, v_next (saturated 16-bit) and fire (v_next >= THRESHOLD) out.
module lif_update import snn_pkg::*; #(
    parameter logic signed [MEM_W-1:0] THRESHOLD  = 16'sd256,
    parameter int                      LEAK_SHIFT = 4
) (
    input  logic signed [MEM_W-1:0] v,
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [MEM_W-1:0] v_next,
    output logic                    fire
);

    localparam int SUM_W = ACC_W + 2;
    localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'((2 ** (MEM_W-1)) - 1);
    localparam logic signed [SUM_W-1:0] MIN_V = ~MAX_V;

    logic signed [MEM_W-1:0] leak;
    logic signed [SUM_W-1:0] v_x;
    logic signed [SUM_W-1:0] leak_x;
    logic signed [SUM_W-1:0] acc_x;
    logic signed [SUM_W-1:0] sum;

    always_comb begin
        leak   = v >>> LEAK_SHIFT;
        v_x    = {{(SUM_W-MEM_W){v[MEM_W-1]}}, v};
        leak_x = {{(SUM_W-MEM_W){leak[MEM_W-1]}}, leak};
        acc_x  = {{(SUM_W-ACC_W){acc[ACC_W-1]}}, acc};
        sum    = v_x - leak_x + acc_x;
        if (sum > MAX_V) begin
            v_next = MAX_V[MEM_W-1:0];
        end else if (sum < MIN_V) begin
            v_next = MIN_V[MEM_W-1:0];
        end else begin
            v_next = sum[MEM_W-1:0];
        end
        fire = (v_next >= THRESHOLD);
    end

endmodule

// File: rtl/spike_integrator.sv
// Frame-based LIF output layer: captures a spike frame, then per neuron
// streams weights from BRAM, accumulates, leaks, fires.
// Ports: clk/reset, i_w_run/i_valid/i_spike/i_clear control+data in;
// addr/ce/we/d/q weight BRAM; o_spike_out/o_done/o_busy status out.
module spike_integrator import snn_pkg::*; #(
    parameter int                      NUM_NEURONS = 10,
    parameter int                      NUM_BEATS   = BEATS,
    parameter logic signed [MEM_W-1:0] THRESHOLD   = 16'sd256,
    parameter int                      LEAK_SHIFT  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_w_run,
    input  logic                   i_valid,
    input  logic [LANES-1:0]       i_spike,
    input  logic                   i_clear,
    output logic [ADDR_W-1:0]      addr,
    output logic                   ce,
    output logic                   we,
    output logic [WORD_W-1:0]      d,
    input  logic [WORD_W-1:0]      q,
    output logic [NUM_NEURONS-1:0] o_spike_out,
    output logic                   o_done,
    output logic                   o_busy
);

    localparam int BEAT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int NRN_W  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
    localparam logic [NRN_W-1:0]  LAST_NRN  = NRN_W'(NUM_NEURONS - 1);

    state_t                     state;
    logic [BEAT_W-1:0]          beat_cnt;
    logic [NRN_W-1:0]           nrn;
    logic [NUM_BEATS*LANES-1:0] spk_buf;
    logic signed [MEM_W-1:0]    mem [NUM_NEURONS];
    logic signed [ACC_W-1:0]    acc;
    logic [LANES-1:0]           spk_d;
    logic                       rd_d;
    logic [NUM_NEURONS-1:0]     fire_mask;
    logic signed [MEM_W-1:0]    v_next;
    logic                       fire;
    logic [ADDR_W-1:0]          next_base;

    assign we     = 1'b0;
    assign d      = '0;
    assign o_busy = (state != ST_IDLE);

    assign next_base = ADDR_W'((int'(nrn) + 1) * NUM_BEATS);

    lif_update #(
        .THRESHOLD  (THRESHOLD),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_lif (
        .v      (mem[nrn]),
        .acc    (acc),
        .v_next (v_next),
        .fire   (fire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            beat_cnt    <= '0;
            nrn         <= '0;
            spk_buf     <= '0;
            acc         <= '0;
            spk_d       <= '0;
            rd_d        <= 1'b0;
            fire_mask   <= '0;
            o_spike_out <= '0;
            o_done      <= 1'b0;
            ce          <= 1'b0;
            addr        <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) mem[i] <= '0;
        end else if (i_clear) begin
            // Abort: o_spike_out keeps the last completed frame.
            state     <= ST_IDLE;
            beat_cnt  <= '0;
            nrn       <= '0;
            acc       <= '0;
            spk_d     <= '0;
            rd_d      <= 1'b0;
            fire_mask <= '0;
            o_done    <= 1'b0;
            ce        <= 1'b0;
            addr      <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) mem[i] <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_w_run) begin
                        state     <= ST_CAPTURE;
                        beat_cnt  <= '0;
                        fire_mask <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (i_valid) begin
                        spk_buf[int'(beat_cnt)*LANES +: LANES] <= i_spike;
                        if (beat_cnt == LAST_BEAT) begin
                            state    <= ST_COMPUTE;
                            beat_cnt <= '0;
                            nrn      <= '0;
                            acc      <= '0;
                            rd_d     <= 1'b0;
                            ce       <= 1'b1;
                            addr     <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    // Spike bits trail the address by one cycle to meet q.
                    rd_d  <= ce;
                    spk_d <= spk_buf[int'(beat_cnt)*LANES +: LANES];
                    if (rd_d) acc <= acc + beat_sum(q, spk_d);
                    if (ce) begin
                        if (beat_cnt == LAST_BEAT) begin
                            ce   <= 1'b0;
                            addr <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                            addr     <= addr + 1'b1;
                        end
                    end else begin
                        // Drain cycle: last word was folded into acc.
                        state <= ST_FIRE;
                    end
                end
                ST_FIRE: begin
                    mem[nrn]       <= fire ? '0 : v_next;
                    fire_mask[nrn] <= fire;
                    if (nrn == LAST_NRN) begin
                        state <= ST_DONE;
                    end else begin
                        state    <= ST_COMPUTE;
                        nrn      <= nrn + 1'b1;
                        beat_cnt <= '0;
                        acc      <= '0;
                        rd_d     <= 1'b0;
                        ce       <= 1'b1;
                        addr     <= next_base;
                    end
                end
                ST_DONE: begin
                    o_spike_out <= fire_mask;
                    o_done      <= 1'b1;
                    nrn         <= '0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spike_integrator.sv
// Scoreboard bench for spike_integrator with a 1-cycle BRAM model.
// Directed frames; a negedge monitor checks each o_done against the queue.
module tb_spike_integrator;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_w_run;
    logic        i_valid;
    logic [3:0]  i_spike;
    logic        i_clear;
    logic [10:0] addr;
    logic        ce;
    logic        we;
    logic [31:0] d;
    logic [31:0] q = '0;
    logic [9:0]  o_spike_out;
    logic        o_done;
    logic        o_busy;

    spike_integrator dut (
        .clk         (clk),
        .reset       (reset),
        .i_w_run     (i_w_run),
        .i_valid     (i_valid),
        .i_spike     (i_spike),
        .i_clear     (i_clear),
        .addr        (addr),
        .ce          (ce),
        .we          (we),
        .d           (d),
        .q           (q),
        .o_spike_out (o_spike_out),
        .o_done      (o_done),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    logic [31:0] wmem [0:2047];
    always @(posedge clk) if (ce) q <= wmem[addr];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_cyc = 0;
    int exp_addr = 0;
    int addr_err = 0;
    int ce_cnt = 0;
    int done_cnt = 0;
    logic [9:0] exp_q [$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                     name, act, act, req, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [9:0] e;
        if (!reset) begin
            if (i_w_run && !o_busy) begin
                exp_addr = 0;
                addr_err = 0;
                ce_cnt   = 0;
            end
            if (ce) begin
                if (int'(addr) != exp_addr) addr_err++;
                exp_addr++;
                ce_cnt++;
            end
            if (o_done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("spike_mask", int'(o_spike_out), int'(e));
                    check("addr_seq_err", addr_err, 0);
                    check("ce_count", ce_cnt, 1440);
                    check("done_latency", cyc - last_cyc, 1461);
                end
            end
        end
    end

    task automatic fill(input logic [31:0] w);
        for (int a = 0; a < 2048; a++) wmem[a] = w;
    endtask

    task automatic send_beats(input logic [3:0] sp, input bit gaps);
        @(negedge clk);
        i_w_run = 1'b1;
        @(negedge clk);
        i_w_run = 1'b0;
        for (int b = 0; b < 144; b++) begin
            if (gaps && (b % 10 == 3)) begin
                i_valid = 1'b0;
                i_spike = 4'hF;
                @(negedge clk);
            end
            i_valid = 1'b1;
            i_spike = sp;
            @(negedge clk);
        end
        i_valid  = 1'b0;
        i_spike  = 4'h0;
        last_cyc = cyc;
    endtask

    task automatic wait_done();
        int start;
        start = done_cnt;
        for (int i = 0; i < 3000 && done_cnt == start; i++) @(negedge clk);
        if (done_cnt == start) check("done_timeout", 0, 1);
    endtask

    task automatic run_frame(input logic [3:0] sp, input logic [9:0] expm,
                             input bit gaps, input bit junk);
        exp_q.push_back(expm);
        send_beats(sp, gaps);
        if (junk) begin
            repeat (400) @(negedge clk);
            i_w_run = 1'b1;
            i_valid = 1'b1;
            i_spike = 4'hF;
            repeat (5) @(negedge clk);
            i_w_run = 1'b0;
            i_valid = 1'b0;
            i_spike = 4'h0;
        end
        wait_done();
    endtask

    task automatic abort_n5(input logic [9:0] held);
        int start;
        bit hit;
        send_beats(4'hF, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            if (ce && addr == 11'd730) hit = 1'b1;
            else @(negedge clk);
        end
        check("abort_reach_n5", int'(hit), 1);
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        check("clear_busy", int'(o_busy), 0);
        check("clear_ce", int'(ce), 0);
        check("clear_addr", int'(addr), 0);
        check("clear_spike_held", int'(o_spike_out), int'(held));
        start = done_cnt;
        repeat (1600) @(negedge clk);
        check("clear_no_done", done_cnt - start, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        i_w_run = 1'b0;
        i_valid = 1'b0;
        i_spike = 4'h0;
        i_clear = 1'b0;
        fill(32'h0);
        repeat (3) @(negedge clk);
        check("rst_spike_out", int'(o_spike_out), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_ce", int'(ce), 0);
        check("rst_addr", int'(addr), 0);
        check("rst_we", int'(we), 0);
        check("rst_d", int'(d), 0);
        reset = 1'b0;

        // No spikes: nothing integrates.
        fill(32'h6464_6464);
        run_frame(4'h0, 10'h000, 1'b1, 1'b0);
        // All spikes, +1 weights: acc = 576 everywhere.
        fill(32'h0101_0101);
        run_frame(4'hF, 10'h3FF, 1'b0, 1'b0);
        // Neuron 3 lane 0 only: 144, then 144-9+144 = 279.
        fill(32'h0);
        for (int b = 0; b < 144; b++) wmem[3*144+b] = 32'h0000_0001;
        run_frame(4'h1, 10'h000, 1'b1, 1'b0);
        run_frame(4'h1, 10'h008, 1'b0, 1'b0);
        // -128 weights: saturate at -32768, then -30144.
        fill(32'h8080_8080);
        run_frame(4'hF, 10'h000, 1'b0, 1'b0);
        fill(32'h0101_0101);
        run_frame(4'hF, 10'h000, 1'b0, 1'b0);
        // Abort mid neuron 5; cleared membranes then fire on 576.
        abort_n5(10'h000);
        run_frame(4'hF, 10'h3FF, 1'b0, 1'b0);
        // Lane 0 +1, others +100: stray beats would force firing.
        fill(32'h6464_6401);
        run_frame(4'h1, 10'h000, 1'b0, 1'b1);
        run_frame(4'h1, 10'h3FF, 1'b0, 1'b0);
        check("pre_reset_spike_out", int'(o_spike_out), 10'h3FF);

        // Reset mid-frame, with i_clear also high.
        fill(32'h0101_0101);
        send_beats(4'hF, 1'b0);
        repeat (200) @(negedge clk);
        reset   = 1'b1;
        i_clear = 1'b1;
        @(negedge clk);
        check("midrst_busy", int'(o_busy), 0);
        check("midrst_spike_out", int'(o_spike_out), 0);
        check("midrst_ce", int'(ce), 0);
        check("midrst_done", int'(o_done), 0);
        reset   = 1'b0;
        i_clear = 1'b0;
        @(negedge clk);
        run_frame(4'hF, 10'h3FF, 1'b1, 1'b0);

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spike_integrator.md
SPIKE_INTEGRATOR -- requirements
Module: spike_integrator

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 10, number of output LIF neurons.
REQ-002 SHALL have parameter NUM_BEATS, default 144, input beats per frame (4 spikes per beat, 576 pixels).
REQ-003 SHALL have parameter THRESHOLD, default 16'sd256, firing threshold (signed 16-bit).
REQ-004 SHALL have parameter LEAK_SHIFT, default 4, leak term = V >>> LEAK_SHIFT.
REQ-005 SHALL have ports: clk  in  1  clock; reset  in  1  synchronous active-high reset. One clock; reset is synchronous and active-high.
REQ-006 SHALL have ports: i_w_run  in  1  frame-start pulse; i_valid  in  1  spike beat valid; i_spike  in  4  spike lanes of current beat; i_clear  in  1  zero membranes / abort.
REQ-007 SHALL have weight BRAM ports: addr  out  11  word address; ce  out  1  read enable; we  out  1  constant 0; d  out  32  constant 0; q  in  32  four signed 8-bit weights, lane k in q[8k+:8].
REQ-008 SHALL have outputs: o_spike_out  out  NUM_NEURONS  fired mask of last frame; o_done  out  1  one-cycle frame-complete pulse; o_busy  out  1  high when not IDLE.

Function
REQ-009 SHALL implement FSM IDLE -> CAPTURE -> COMPUTE -> FIRE -> (COMPUTE | DONE) -> IDLE.
REQ-010 SHALL leave IDLE for CAPTURE only on i_w_run; i_w_run in any other state is ignored.
REQ-011 SHALL in CAPTURE store i_spike into a 576-bit buffer at index beat*4+lane on each i_valid cycle, beat counter 0..NUM_BEATS-1, advancing only on i_valid; gaps in i_valid are tolerated.
REQ-012 SHALL enter COMPUTE the cycle after beat NUM_BEATS-1 is captured; i_valid outside CAPTURE is ignored.
REQ-013 SHALL in COMPUTE for neuron n (0..NUM_NEURONS-1) issue ce=1, addr = n*NUM_BEATS + b for b = 0..NUM_BEATS-1, one per cycle.
REQ-014 SHALL assume 1-cycle BRAM read latency: q for address issued at cycle t is used at t+1 with the spike bits of beat b delayed to match.
REQ-015 SHALL accumulate, per beat, the sum of weights whose lane spike bit is 1, into an 18-bit signed accumulator cleared at start of each neuron.
REQ-016 SHALL enter FIRE one cycle after the last address (drain), i.e. 146 cycles per neuron, 1460 cycles for default parameters.
REQ-017 SHALL in FIRE compute Vn = V - (V >>> LEAK_SHIFT) + acc, saturated to signed 16-bit [-32768, 32767].
REQ-018 SHALL, if Vn >= THRESHOLD, set fire bit n and store V = 0; else store V = Vn.
REQ-019 SHALL go from FIRE to COMPUTE for n+1, or to DONE after neuron NUM_NEURONS-1.
REQ-020 SHALL in DONE register the fire mask into o_spike_out, pulse o_done for exactly one cycle, return to IDLE; o_spike_out holds until next DONE.
REQ-021 SHALL keep membranes across frames; only reset or i_clear zeroes them.
REQ-022 SHALL on i_clear in any state zero all membranes, fire mask and counters, return to IDLE without o_done; o_spike_out unchanged.
REQ-023 SHALL hold ce=0 and addr=0 outside COMPUTE.

Reset
REQ-024 SHALL on reset: state IDLE, all membranes 0, accumulator 0, counters 0, spike buffer 0, o_spike_out 0, o_done 0, o_busy 0, ce 0, addr 0.
REQ-025 SHALL give reset priority over i_clear and all other inputs, including mid-frame.

Structure
REQ-026 SHALL place FSM state encoding, NUM_BEATS, lane count (4), weight width (8), membrane width (16) and accumulator width (18) in shared package snn_pkg.
REQ-027 SHALL implement the leak/add/saturate/threshold step (REQ-017/018) as combinational sub-module lif_update, instanced once.

Verification
REQ-028 All spikes 0, any weights -> o_spike_out=0, membranes stay 0, o_done 1461+ cycles after last beat.
REQ-029 All spikes 1, all weights +1 -> acc=576 per neuron, o_spike_out=10'h3FF, all membranes 0.
REQ-030 Neuron 3 lane0 weights +1 (others 0), lane0 spikes all beats -> frame1 V3=144, no fire; frame2 V3=144-9+144=279 -> o_spike_out=10'h008, V3=0.
REQ-031 All weights -128, all spikes 1 -> acc=-73728, V saturates to -32768, o_spike_out=0.
REQ-032 i_clear asserted mid-COMPUTE (neuron 5) -> IDLE next cycle, membranes 0, no o_done, ce=0.
REQ-033 i_w_run and extra i_valid beats during COMPUTE -> ignored, addr sequence and result unchanged versus clean run.
